// File: rtl/arb_mux.sv
// Round-robin merge of SIZE valid/ready streams onto one output stream, tagging each beat with its source index.
// Optional macro ARB_MUX_OUT_REG_EN inserts a one-entry output register after the arbiter (1 cycle latency).
module arb_mux #(
    parameter int SIZE  = 2,
    parameter int WIDTH = 16,
    parameter int IDXW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE-1:0]         din_valid,
    output logic [SIZE-1:0]         din_ready,
    input  logic [SIZE*WIDTH-1:0]   din_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [WIDTH-1:0]        dout_data,
    output logic [IDXW-1:0]         dout_idx
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDXW-1:0]  prio_ptr_q, prio_ptr_d;
    logic [IDXW-1:0]  lock_idx_q, lock_idx_d;

    logic [IDXW-1:0]  scan_sel;
    logic [IDXW-1:0]  sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             arb_valid;
    logic             arb_ready;
    logic             arb_fire;
    int               scan_best;
    int               scan_dist;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
        int nxt;
        nxt = int'(idx) + 1;
        if (nxt >= SIZE) begin
            nxt = 0;
        end
        return IDXW'(nxt);
    endfunction

    // Pick the valid input closest (circularly) to prio_ptr; distance 0 wins outright.
    always_comb begin
        scan_sel  = '0;
        scan_best = SIZE;
        scan_dist = 0;
        for (int i = 0; i < SIZE; i++) begin
            scan_dist = i - int'(prio_ptr_q);
            if (scan_dist < 0) begin
                scan_dist = scan_dist + SIZE;
            end
            if (din_valid[i] && (scan_dist < scan_best)) begin
                scan_best = scan_dist;
                scan_sel  = IDXW'(i);
            end
        end
    end

    assign sel = (state_q == ST_LOCKED) ? lock_idx_q : scan_sel;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (sel == IDXW'(i)) begin
                sel_valid = din_valid[i];
                sel_data  = din_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset masks the request side so nothing transfers on the reset cycle.
    assign arb_valid = !rst && ((state_q == ST_LOCKED) ? sel_valid : (|din_valid));
    assign arb_fire  = arb_valid && arb_ready;

    always_comb begin
        din_ready = '0;
        for (int i = 0; i < SIZE; i++) begin
            din_ready[i] = arb_fire && (sel == IDXW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (arb_ready) begin
                        prio_ptr_d = wrap_inc(sel);
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (arb_ready) begin
                    state_d    = ST_IDLE;
                    prio_ptr_d = wrap_inc(lock_idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_ptr_q <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef ARB_MUX_OUT_REG_EN
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;

    // The register accepts a new beat whenever it is empty or draining this cycle.
    assign arb_ready = !out_vld_q || dout_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        if (arb_fire) begin
            out_vld_d  = 1'b1;
            out_data_d = sel_data;
            out_idx_d  = sel;
        end else if (dout_ready) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
        end
        out_data_q <= out_data_d;
        out_idx_q  <= out_idx_d;
    end

    assign dout_valid = out_vld_q && !rst;
    assign dout_data  = out_data_q;
    assign dout_idx   = out_idx_q;
`else
    assign arb_ready  = dout_ready;
    assign dout_valid = arb_valid;
    assign dout_data  = sel_data;
    assign dout_idx   = sel;
`endif

endmodule
